// File: rtl/div_mse_accumulator.sv
// Error-metric stage for the 16/8 approximate divider: recomputes the exact quotient with a
// sequential restoring divider and accumulates squared error, max |error| and sample counts.
module div_mse_accumulator #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      n,
    input  logic [7:0]       d,
    input  logic [7:0]       q_apx,
    input  logic [7:0]       r_apx,
    input  logic             clear,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] excl_cnt,
    output logic [ACC_W-1:0] err_sq_acc,
    output logic [7:0]       err_max,
    output logic             acc_sat,
    output logic             done
);

    // Wide enough to hold acc + a 16-bit square plus a carry, even for small ACC_W.
    localparam int unsigned SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;

    typedef enum logic [1:0] {StIdle, StDiv, StAcc} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [2:0]         r_iter;
    logic [7:0]         r_n_lo;
    logic [7:0]         r_d;
    logic [7:0]         r_q_apx;
    logic [7:0]         r_r_apx;
    logic [7:0]         r_q;
    logic [8:0]         r_pr;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   r_excl_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [7:0]         r_err_max;
    logic               r_acc_sat;
    logic               r_done;

    logic               w_accept;
    logic               w_excl;
    logic [8:0]         w_t;
    logic               w_ge;
    logic [8:0]         w_pr_next;
    logic [8:0]         w_err;
    logic [8:0]         w_err_neg;
    logic [7:0]         w_abs;
    logic [15:0]        w_sq;
    logic [SUM_W-1:0]   w_sum;
    logic               w_acc_ovf;
    logic               w_unused_dbg;

    assign in_ready   = (r_state == StIdle) & ~clear & ~rst;
    assign busy       = (r_state != StIdle);
    assign w_accept   = in_valid & in_ready;
    // Quotient only fits in 8 bits when the dividend's upper byte is below the divisor.
    assign w_excl     = (d == 8'd0) | (n[15:8] >= d);

    assign w_t        = {r_pr[7:0], r_n_lo[r_iter]};
    assign w_ge       = (w_t >= {1'b0, r_d});
    assign w_pr_next  = w_ge ? (w_t - {1'b0, r_d}) : w_t;

    assign w_err      = {1'b0, r_q} - {1'b0, r_q_apx};
    assign w_err_neg  = 9'd0 - w_err;
    assign w_abs      = w_err[8] ? w_err_neg[7:0] : w_err[7:0];
    assign w_sq       = 16'(w_abs) * 16'(w_abs);
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_sq);
    assign w_acc_ovf  = |w_sum[SUM_W-1:ACC_W];

    // Remainder and the registered approximate remainder are kept for debug visibility only.
    assign w_unused_dbg = ^{r_r_apx, r_pr[8]};

    assign sample_cnt = r_sample_cnt;
    assign excl_cnt   = r_excl_cnt;
    assign err_sq_acc = r_acc;
    assign err_max    = r_err_max;
    assign acc_sat    = r_acc_sat;
    assign done       = r_done;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; clear aborts anything in flight.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (w_accept && !w_excl) w_state_next = StDiv;
                StDiv:   if (r_iter == 3'd0) w_state_next = StAcc;
                StAcc:   w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Sample capture, restoring division and statistics commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter       <= 3'd0;
            r_n_lo       <= 8'd0;
            r_d          <= 8'd0;
            r_q_apx      <= 8'd0;
            r_r_apx      <= 8'd0;
            r_q          <= 8'd0;
            r_pr         <= 9'd0;
            r_sample_cnt <= '0;
            r_excl_cnt   <= '0;
            r_acc        <= '0;
            r_err_max    <= 8'd0;
            r_acc_sat    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_sample_cnt <= '0;
                r_excl_cnt   <= '0;
                r_acc        <= '0;
                r_err_max    <= 8'd0;
                r_acc_sat    <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_accept) begin
                            r_n_lo  <= n[7:0];
                            r_d     <= d;
                            r_q_apx <= q_apx;
                            r_r_apx <= r_apx;
                            if (w_excl) begin
                                if (&r_excl_cnt) r_acc_sat <= 1'b1;
                                else r_excl_cnt <= r_excl_cnt + CNT_W'(1);
                            end else begin
                                r_pr   <= {1'b0, n[15:8]};
                                r_iter <= 3'd7;
                            end
                        end
                    end
                    StDiv: begin
                        r_pr   <= w_pr_next;
                        r_q    <= {r_q[6:0], w_ge};
                        r_iter <= r_iter - 3'd1;
                    end
                    StAcc: begin
                        r_done <= 1'b1;
                        if (w_acc_ovf) begin
                            r_acc     <= '1;
                            r_acc_sat <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        if (&r_sample_cnt) r_acc_sat <= 1'b1;
                        else r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                        if (w_abs > r_err_max) r_err_max <= w_abs;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
